// File: rtl/fpu_exc_classifier_pkg.sv
// Shared definitions for the FPU operand exception classifier: op codes,
// flag bit positions, the per-operand class record and the flag rules.
package fpu_exc_pkg;

    localparam logic [1:0] OP_ADDITION       = 2'd0;
    localparam logic [1:0] OP_SUBTRACTION    = 2'd1;
    localparam logic [1:0] OP_MULTIPLICATION = 2'd2;
    localparam logic [1:0] OP_DIVISION       = 2'd3;

    localparam int FLAG_W        = 4;
    localparam int FLAG_INVALID  = 0;
    localparam int FLAG_NAN_IN   = 1;
    localparam int FLAG_DIV_ZERO = 2;
    localparam int FLAG_INF_IN   = 3;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sign;
    } operand_class_t;

    // A NaN on either side masks every other flag.
    function automatic logic [FLAG_W-1:0] exc_flags(input logic [1:0]      op,
                                                    input operand_class_t a,
                                                    input operand_class_t b);
        logic [FLAG_W-1:0] f;
        f = 4'b0000;
        if (a.nan || b.nan) begin
            f[FLAG_NAN_IN] = 1'b1;
        end else begin
            f[FLAG_INF_IN] = a.inf | b.inf;
            case (op)
                OP_ADDITION:       f[FLAG_INVALID] = a.inf & b.inf & (a.sign ^ b.sign);
                OP_SUBTRACTION:    f[FLAG_INVALID] = a.inf & b.inf & ~(a.sign ^ b.sign);
                OP_MULTIPLICATION: f[FLAG_INVALID] = (a.zero & b.inf) | (a.inf & b.zero);
                OP_DIVISION: begin
                    f[FLAG_INVALID]  = (a.zero & b.zero) | (a.inf & b.inf);
                    f[FLAG_DIV_ZERO] = b.zero & ~a.zero & ~a.inf;
                end
                default:           f[FLAG_INVALID] = 1'b0;
            endcase
        end
        return f;
    endfunction

    function automatic logic is_exception(input logic [FLAG_W-1:0] f);
        return f[FLAG_INVALID] | f[FLAG_NAN_IN] | f[FLAG_DIV_ZERO];
    endfunction

endpackage

// File: rtl/fpu_exc_classifier_if.sv
// Operand-issue / result bus of the exception classifier; the classifier
// takes the slave side, the issue stage and datapath the master side.
interface fpu_exc_classifier_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       FP_OPERATION;
    logic [W-1:0]     OP_A;
    logic [W-1:0]     OP_B;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OP_IS_EXCEPTION;
    logic [3:0]       EXC_FLAGS;
    logic [3:0]       STICKY_FLAGS;
    logic             STICKY_CLR;
    logic [CNT_W-1:0] EXC_COUNT;

    modport master (
        output IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
        input  IN_READY, OUT_VALID, OP_IS_EXCEPTION, EXC_FLAGS, STICKY_FLAGS, EXC_COUNT
    );

    modport slave (
        input  IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
        output IN_READY, OUT_VALID, OP_IS_EXCEPTION, EXC_FLAGS, STICKY_FLAGS, EXC_COUNT
    );
endinterface

// File: rtl/fpu_exc_classifier_operand_classify.sv
// Combinational decode of one sign/exponent/mantissa operand into its
// NaN / infinity / zero class plus sign.
module fpu_operand_classify
    import fpu_exc_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output operand_class_t       class_o
);
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign exp_s = op_i[MAN_W +: EXP_W];
    assign man_s = op_i[MAN_W-1:0];

    // Field decode; zero ignores the sign bit.
    always_comb begin
        class_o.nan  = (&exp_s) & (|man_s);
        class_o.inf  = (&exp_s) & ~(|man_s);
        class_o.zero = ~(|exp_s) & ~(|man_s);
        class_o.sign = op_i[EXP_W+MAN_W];
    end
endmodule

// File: rtl/fpu_exc_classifier.sv
// Two-stage pipelined FPU operand exception classifier with sticky flags.
// Define FPU_EXC_COUNTER_EN to build the saturating exception counter.
module fpu_exc_classifier
    import fpu_exc_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int CNT_W = 8
) (
    input logic                CLK,
    input logic                RST_N,
    fpu_exc_classifier_if.slave bus
);
    operand_class_t    cls_a_s, cls_b_s;
    logic              s2_adv_s, s1_adv_s, out_hs_s;

    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_op_q, s1_op_d;
    operand_class_t    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic              out_valid_q, out_valid_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              exc_q, exc_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i    (bus.OP_A),
        .class_o (cls_a_s)
    );

    fpu_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i    (bus.OP_B),
        .class_o (cls_b_s)
    );

    assign s2_adv_s = ~out_valid_q | bus.OUT_READY;
    assign s1_adv_s = ~s1_valid_q | s2_adv_s;
    assign out_hs_s = out_valid_q & bus.OUT_READY;

    // Pipeline next state: S1 captures classes, S2 captures flags.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        exc_d       = exc_q;
        if (s1_adv_s && bus.IN_VALID) begin
            s1_valid_d = 1'b1;
            s1_op_d    = bus.FP_OPERATION;
            s1_a_d     = cls_a_s;
            s1_b_d     = cls_b_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s && s1_valid_q) begin
            out_valid_d = 1'b1;
            flags_d     = exc_flags(s1_op_q, s1_a_q, s1_b_q);
            exc_d       = is_exception(flags_d);
        end else if (s2_adv_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Clear wins over accumulation, but the result handshaking now survives it.
    always_comb begin
        sticky_d = sticky_q;
        if (bus.STICKY_CLR) begin
            sticky_d = out_hs_s ? flags_q : 4'b0000;
        end else if (out_hs_s) begin
            sticky_d = sticky_q | flags_q;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Pipeline and sticky state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'd0;
            s1_a_q      <= 4'b0000;
            s1_b_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
            exc_q       <= 1'b0;
            sticky_q    <= 4'b0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            exc_q       <= exc_d;
            sticky_q    <= sticky_d;
        end
    end

`ifdef FPU_EXC_COUNTER_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Saturating exception counter; a coincident clear restarts from this result.
    always_comb begin
        count_d = count_q;
        if (bus.STICKY_CLR) begin
            count_d = (out_hs_s && exc_q) ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (out_hs_s && exc_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.EXC_COUNT = count_q;
`else
    assign bus.EXC_COUNT = {CNT_W{1'b0}};
`endif

    assign bus.IN_READY        = s1_adv_s;
    assign bus.OUT_VALID       = out_valid_q;
    assign bus.EXC_FLAGS       = flags_q;
    assign bus.OP_IS_EXCEPTION = exc_q;
    assign bus.STICKY_FLAGS    = sticky_q;
endmodule

// File: tb/tb_fpu_exc_classifier.sv
// Self-checking bench for fpu_exc_classifier (E4M3, 2-bit counter): a
// transaction-level model plus directed vectors with literal expectations.
module tb_fpu_exc_classifier;
    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FPU_EXC_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fpu_exc_classifier_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus ();

    fpu_exc_classifier #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flags straight from the IEEE-style rules on raw fields.
    function automatic logic [3:0] ref_flags(input int op, input int a, input int b);
        int emax, ea, ma, eb, mb;
        bit sa, sb, na, nb, ia, ib, za, zb, inv, dz;
        emax = (1 << EXP_W) - 1;
        ea = (a >> MAN_W) & emax;  ma = a & ((1 << MAN_W) - 1);
        eb = (b >> MAN_W) & emax;  mb = b & ((1 << MAN_W) - 1);
        sa = ((a >> (EXP_W + MAN_W)) & 1) == 1;
        sb = ((b >> (EXP_W + MAN_W)) & 1) == 1;
        na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
        ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
        za = (ea == 0) && (ma == 0);     zb = (eb == 0) && (mb == 0);
        if (na || nb) return 4'b0010;
        inv = 1'b0;
        dz  = 1'b0;
        if (op == 0)      inv = ia && ib && (sa != sb);
        else if (op == 1) inv = ia && ib && (sa == sb);
        else if (op == 2) inv = (za && ib) || (ia && zb);
        else begin
            inv = (za && zb) || (ia && ib);
            dz  = zb && !za && !ia;
        end
        return {ia || ib, dz, 1'b0, inv};
    endfunction

    function automatic bit is_exc(input logic [3:0] f);
        return (f[0] || f[1] || f[2]);
    endfunction

    // Directed vectors with hand-derived flag expectations.
    logic [1:0] v_op  [NV] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                               2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3};
    logic [7:0] v_a   [NV] = '{8'h78, 8'h78, 8'hF8, 8'hF8, 8'h79, 8'h00, 8'h38,
                               8'h38, 8'h00, 8'h78, 8'h38, 8'hF8, 8'h80, 8'h00};
    logic [7:0] v_b   [NV] = '{8'hF8, 8'h78, 8'hF8, 8'h78, 8'h38, 8'h78, 8'hF8,
                               8'h80, 8'h80, 8'hF8, 8'h00, 8'h00, 8'hF8, 8'h79};
    logic [3:0] v_exp [NV] = '{4'b1001, 4'b1000, 4'b1001, 4'b1000, 4'b0010, 4'b1001, 4'b1000,
                               4'b0100, 4'b0001, 4'b1001, 4'b0000, 4'b1000, 4'b1001, 4'b0010};

    // Transaction model: FIFO of in-flight results, each tagged with its accept edge.
    typedef struct {
        logic [3:0] f;
        int         edge_no;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_sticky = 4'b0000;
    int         m_cnt = 0;
    int         edge_cnt = 0;
    bit         m_v, m_r, m_hs, m_acc;
    ent_t       m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_sticky = 4'b0000;
            m_cnt = 0;
        end else begin
            m_v   = (q.size() > 0) && (q[0].edge_no < edge_cnt);
            m_r   = (q.size() < 2) || (bus.OUT_READY == 1'b1);
            m_hs  = m_v && (bus.OUT_READY == 1'b1);
            m_acc = (bus.IN_VALID == 1'b1) && m_r;
            if (bus.STICKY_CLR == 1'b1) begin
                m_sticky = 4'b0000;
                m_cnt = 0;
                if (m_hs) begin
                    m_sticky = q[0].f;
                    if (CNT_EN && is_exc(q[0].f)) m_cnt = 1;
                end
            end else if (m_hs) begin
                m_sticky = m_sticky | q[0].f;
                if (CNT_EN && is_exc(q[0].f) && m_cnt < CNT_MAX) m_cnt++;
            end
            if (m_hs) void'(q.pop_front());
            edge_cnt++;
            if (m_acc) begin
                m_e.f = ref_flags(bus.FP_OPERATION, bus.OP_A, bus.OP_B);
                m_e.edge_no = edge_cnt;
                q.push_back(m_e);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    bit c_v;
    initial forever begin
        @(negedge clk);
        c_v = (q.size() > 0) && (q[0].edge_no < edge_cnt);
        chk("in_ready", bus.IN_READY, ((q.size() < 2) || (bus.OUT_READY == 1'b1)));
        chk("out_valid", bus.OUT_VALID, c_v);
        if (c_v) begin
            chk("exc_flags", bus.EXC_FLAGS, q[0].f);
            chk("op_is_exception", bus.OP_IS_EXCEPTION, is_exc(q[0].f));
        end
        chk("sticky_flags", bus.STICKY_FLAGS, m_sticky);
        chk("exc_count", bus.EXC_COUNT, m_cnt);
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit r;
        int n;
        bus.FP_OPERATION = op;
        bus.OP_A = a;
        bus.OP_B = b;
        bus.IN_VALID = 1'b1;
        r = 1'b0;
        n = 0;
        while (!r && n < 200) begin
            @(negedge clk);
            r = bus.IN_READY;
            @(posedge clk);
            #1;
            n++;
        end
        bus.IN_VALID = 1'b0;
        chk("send_accept", r, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        int n;
        bus.IN_VALID = 1'b0;
        bus.FP_OPERATION = 2'd0;
        bus.OP_A = 8'h00;
        bus.OP_B = 8'h00;
        bus.OUT_READY = 1'b1;
        bus.STICKY_CLR = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.OUT_VALID, 0);
        chk("rst_flags", bus.EXC_FLAGS, 0);
        chk("rst_exc", bus.OP_IS_EXCEPTION, 0);
        chk("rst_sticky", bus.STICKY_FLAGS, 0);
        chk("rst_count", bus.EXC_COUNT, 0);
        chk("rst_in_ready", bus.IN_READY, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Isolated ops: pin the model, then check the 2-cycle latency literally.
        for (int i = 0; i < NV; i++) begin
            chk("model_pin", ref_flags(v_op[i], v_a[i], v_b[i]), v_exp[i]);
            send(v_op[i], v_a[i], v_b[i]);
            @(negedge clk);
            chk("lat1_valid", bus.OUT_VALID, 0);
            @(negedge clk);
            chk("lat2_valid", bus.OUT_VALID, 1);
            chk("lat2_flags", bus.EXC_FLAGS, v_exp[i]);
            chk("lat2_exc", bus.OP_IS_EXCEPTION, is_exc(v_exp[i]));
            @(posedge clk);
            #1;
        end

        // Back-to-back at full throughput.
        for (int i = 0; i < NV; i++) send(v_op[i], v_a[i], v_b[i]);
        drain();

        // Stall with four ops queued behind a blocked output.
        bus.OUT_READY = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(v_op[i], v_a[i], v_b[i]);
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready", bus.IN_READY, 0);
                chk("stall_valid", bus.OUT_VALID, 1);
                chk("stall_flags", bus.EXC_FLAGS, v_exp[0]);
                repeat (2) @(negedge clk);
                chk("stall_flags_held", bus.EXC_FLAGS, v_exp[0]);
                chk("stall_exc_held", bus.OP_IS_EXCEPTION, 1);
                @(posedge clk);
                #1;
                bus.OUT_READY = 1'b1;
            end
        join
        drain();

        // Saturation: clear, then five exception results.
        bus.STICKY_CLR = 1'b1;
        @(posedge clk);
        #1;
        bus.STICKY_CLR = 1'b0;
        chk("clr_sticky", bus.STICKY_FLAGS, 0);
        chk("clr_count", bus.EXC_COUNT, 0);
        send(2'd0, 8'h79, 8'h38);
        send(2'd0, 8'h78, 8'hF8);
        send(2'd3, 8'h38, 8'h00);
        send(2'd2, 8'h00, 8'h78);
        send(2'd1, 8'h79, 8'h79);
        drain();
        chk("sat_sticky", bus.STICKY_FLAGS, 4'b1111);
        chk("sat_count", bus.EXC_COUNT, CNT_EN ? 3 : 0);

        // Clear coincident with an exception handshake keeps only that result.
        send(2'd3, 8'h38, 8'h80);
        n = 0;
        while (bus.OUT_VALID !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("clr_hs_valid", bus.OUT_VALID, 1);
        bus.STICKY_CLR = 1'b1;
        @(posedge clk);
        #1;
        bus.STICKY_CLR = 1'b0;
        @(negedge clk);
        chk("clr_hs_sticky", bus.STICKY_FLAGS, 4'b0100);
        chk("clr_hs_count", bus.EXC_COUNT, CNT_EN ? 1 : 0);
        @(posedge clk);
        #1;

        // Reset with both stages full drops everything.
        bus.OUT_READY = 1'b0;
        send(2'd0, 8'h78, 8'hF8);
        send(2'd3, 8'h38, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.OUT_VALID, 0);
        chk("mid_rst_flags", bus.EXC_FLAGS, 0);
        chk("mid_rst_exc", bus.OP_IS_EXCEPTION, 0);
        chk("mid_rst_sticky", bus.STICKY_FLAGS, 0);
        chk("mid_rst_count", bus.EXC_COUNT, 0);
        chk("mid_rst_in_ready", bus.IN_READY, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.OUT_VALID, 0);
            chk("post_rst_in_ready", bus.IN_READY, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/fpu_exc_classifier.md
Name: fpu_exc_classifier

Overview:
Parametrised, pipelined successor to the FPU's combinational operand exception check. Classifies operand pairs for ADD/SUB/MUL/DIV in a generic sign/exponent/mantissa format into IEEE-style exception flags. Adds valid/ready flow control, sticky status flags and an exception counter. Sits between the FPU operand issue stage and the arithmetic datapath; the datapath consumes OP_IS_EXCEPTION to bypass computation.

Parameters:
EXP_W, 4, exponent field width (>=2)
MAN_W, 3, mantissa field width (>=1); word width W = 1+EXP_W+MAN_W (default 8)
CNT_W, 8, exception counter width (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operand pair valid
IN_READY  out  1  block can accept
FP_OPERATION  in  2  0=ADD 1=SUB 2=MUL 3=DIV
OP_A  in  W  operand A
OP_B  in  W  operand B
OUT_VALID  out  1  result valid
OUT_READY  in  1  downstream accepts
OP_IS_EXCEPTION  out  1  INVALID|NAN_IN|DIV_ZERO
EXC_FLAGS  out  4  [0]INVALID [1]NAN_IN [2]DIV_ZERO [3]INF_IN
STICKY_FLAGS  out  4  OR of EXC_FLAGS since reset/clear
STICKY_CLR  in  1  clear sticky flags and counter
EXC_COUNT  out  CNT_W  saturating count of exception results

Behaviour:
- Single clock CLK; RST_N asynchronous, active-low. All regs reset to 0: OUT_VALID, EXC_FLAGS, OP_IS_EXCEPTION, STICKY_FLAGS and EXC_COUNT = 0. IN_READY = 1 out of reset.
- Field decode: NaN = exp all-ones, man != 0. Inf = exp all-ones, man == 0. Zero = exp == 0, man == 0 (either sign).
- Stage 1 (S1): on IN_VALID&&IN_READY, register the op code, each operand's class (nan/inf/zero) and its sign.
- Stage 2 (S2): register the flags.
- Latency: 2 cycles from accept to OUT_VALID. Throughput: 1 per cycle.
- Flow control:
  - s2_adv = !OUT_VALID || OUT_READY
  - s1_adv = !s1_valid || s2_adv
  - IN_READY = s1_adv (combinational)
- While OUT_VALID && !OUT_READY: all outputs held stable. No loss, no duplication, order preserved.
- Flag rules (NaN precedence):
  - If either operand is NaN: NAN_IN=1, all other flags 0.
  - Otherwise:
    - INF_IN = either operand is inf.
    - INVALID:
      - ADD: inf+inf with opposite signs.
      - SUB: inf-inf with equal signs (covers -inf - -inf).
      - MUL: zero*inf, either order.
      - DIV: 0/0 or inf/inf.
    - DIV_ZERO: DIV with B zero and A finite nonzero.
- OP_IS_EXCEPTION = INVALID|NAN_IN|DIV_ZERO. INF_IN alone is not an exception.
- Sticky and counter update only on the output handshake (OUT_VALID&&OUT_READY):
  - STICKY_FLAGS |= EXC_FLAGS.
  - EXC_COUNT increments if OP_IS_EXCEPTION, saturating at all-ones.
- STICKY_CLR alone: STICKY_FLAGS and EXC_COUNT = 0 next cycle.
- STICKY_CLR coincident with a handshake: old state is discarded and the new result is kept. STICKY_FLAGS = EXC_FLAGS; EXC_COUNT = OP_IS_EXCEPTION ? 1 : 0.
- Reset mid-operation: in-flight S1/S2 entries are dropped; no output is produced for them.

Optional Feature:
FPU_EXC_COUNTER_EN:
- Defined: EXC_COUNT register and saturation logic are present as described.
- Undefined: no counter flops; EXC_COUNT is tied to 0; STICKY_CLR affects STICKY_FLAGS only.

Decomposition:
- Shared package fpu_exc_pkg:
  - op code constants _ADDITION/_SUBTRACTION/_MULTIPLICATION/_DIVISION
  - flag bit index constants
  - operand class struct {nan, inf, zero, sign}
- One sub-module fpu_operand_classify (parametrised EXP_W/MAN_W, combinational), instantiated twice in S1.

Test Plan (default E4M3; +inf=0x78, -inf=0xF8, NaN=0x79, +0=0x00, -0=0x80, 1.0=0x38):
1. ADD 0x78,0xF8 -> 2 cycles later OUT_VALID=1, EXC_FLAGS=4'b1001, OP_IS_EXCEPTION=1. ADD 0x78,0x78 -> 4'b1000, exception 0.
2. SUB 0xF8,0xF8 -> 4'b1001, exception 1. SUB 0xF8,0x78 -> 4'b1000, exception 0. SUB 0x79,0x38 -> 4'b0010, exception 1.
3. MUL 0x00,0x78 -> 4'b1001. MUL 0x38,0xF8 -> 4'b1000, exception 0. DIV 0x38,0x80 -> 4'b0100. DIV 0x00,0x80 -> 4'b0001. DIV 0x78,0xF8 -> 4'b1001.
4. Hold OUT_READY=0 for 6 cycles while pushing 4 ops back-to-back:
   - IN_READY drops after 2 accepts.
   - Outputs stay stable while stalled.
   - Release gives results in order, one per cycle, with no loss.
5. CNT_W=2 with macro defined; 5 exception results -> EXC_COUNT saturates at 3, STICKY_FLAGS = OR of seen flags. Then STICKY_CLR coincident with an exception handshake -> EXC_COUNT=1, STICKY_FLAGS=that result's flags.
6. Assert RST_N low with both stages full -> all outputs 0 immediately; after release IN_READY=1 and no stale OUT_VALID. With the macro undefined, EXC_COUNT stays 0 throughout.
